ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_queue.sv | 91 +++++++++
 tb/tb_ir_queue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction register fed by a small prefetch FIFO with sync-driven pop, same-cycle bypass and flush.
// Build option: define IR_INJECT_EN to add the irq_req port and BRK (8'h00) injection on sync.
module ir_queue #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_OP = 8'h6C
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           data,
    input  logic                       data_valid,
    input  logic                       sync,
    input  logic                       flush,
`ifdef IR_INJECT_EN
    input  logic                       irq_req,
`endif
    output logic [WIDTH-1:0]           ir,
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    logic inj;
    logic q_empty;
    logic pop;
    logic bypass;
    logic push;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A flush in the same cycle makes the queue look empty to sync.
    always_comb begin
        inj = 1'b0;
`ifdef IR_INJECT_EN
        inj = sync & irq_req;
`endif
        q_empty = flush | empty;
        pop     = sync & ~inj & ~q_empty;
        bypass  = sync & ~inj & q_empty & data_valid;
        stall   = sync & ~inj & q_empty & ~data_valid;
        push    = data_valid & ~bypass & (flush | ~full | pop);
        drop    = data_valid & ~bypass & ~flush & full & ~pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            ir       <= RESET_OP;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= push ? AW'(1) : '0;
                count  <= push ? CW'(1) : '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (drop) overflow <= 1'b1;

            if (inj)         ir <= '0;
            else if (pop)    ir <= mem[rd_ptr];
            else if (bypass) ir <= data;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem[flush ? '0 : wr_ptr] <= data;
    end

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: stimulus queues expected IR loads, a negedge monitor checks them.
module tb_ir_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = '0;
    logic       data_valid = 1'b0;
    logic       sync = 1'b0;
    logic       flush = 1'b0;
    logic       irq_req = 1'b0;
    logic [7:0] ir;
    logic       stall;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q [$];
    logic       pending = 1'b0;

    always #5 clk = ~clk;

    ir_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .sync       (sync),
        .flush      (flush),
`ifdef IR_INJECT_EN
        .irq_req    (irq_req),
`endif
        .ir         (ir),
        .stall      (stall),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a sync without stall seen at one negedge means ir changed at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_load: got ir=%0h expected no load", ir);
                end else begin
                    chk("ir_load", ir, exp_q.pop_front());
                end
            end
            pending = sync && !stall;
        end
    end

    // One cycle of stimulus; stall is checked while inputs are stable.
    task automatic step(input logic dv, input logic [7:0] d, input logic sy, input logic fl,
                        input logic irq, input logic ld, input logic [7:0] exp_ir,
                        input logic exp_stall);
        data_valid = dv; data = d; sync = sy; flush = fl; irq_req = irq;
        if (ld) exp_q.push_back(exp_ir);
        @(negedge clk);
        chk("stall", {7'b0, stall}, {7'b0, exp_stall});
        @(posedge clk);
        #1;
        data_valid = 1'b0; sync = 1'b0; flush = 1'b0; irq_req = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sync_ld(input logic [7:0] exp_ir);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, exp_ir, 1'b0);
    endtask

    task automatic check_state(input string tag, input int c, input logic e, input logic f,
                               input logic o);
        chk({tag, "_count"}, {5'b0, count}, 8'(c));
        chk({tag, "_empty"}, {7'b0, empty}, {7'b0, e});
        chk({tag, "_full"}, {7'b0, full}, {7'b0, f});
        chk({tag, "_overflow"}, {7'b0, overflow}, {7'b0, o});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset_ir", ir, 8'h6C);
        chk("reset_stall", {7'b0, stall}, 8'h00);
        check_state("reset", 0, 1'b1, 1'b0, 1'b0);

        push_b(8'hA9); push_b(8'h05); push_b(8'h8D);
        chk("three_full", {7'b0, full}, 8'h00);
        push_b(8'h00);
        check_state("four", 4, 1'b0, 1'b1, 1'b0);

        push_b(8'hEA);
        check_state("ovf", 4, 1'b0, 1'b1, 1'b1);

        sync_ld(8'hA9); sync_ld(8'h05); sync_ld(8'h8D); sync_ld(8'h00);
        check_state("drained", 0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 8'h4C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h4C, 1'b0);
        check_state("bypass", 0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("stall_hold_ir", ir, 8'h4C);

        push_b(8'h11); push_b(8'h22); push_b(8'h33);
        chk("pre_flush_count", {5'b0, count}, 8'd3);
        step(1'b1, 8'h60, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("flush_push_count", {5'b0, count}, 8'd1);
        sync_ld(8'h60);
        chk("after_60_count", {5'b0, count}, 8'd0);

        // Pop plus push while full keeps count at DEPTH without overflow side effects.
        push_b(8'h01); push_b(8'h02); push_b(8'h03); push_b(8'h04);
        step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        check_state("popush", 4, 1'b0, 1'b1, 1'b1);
        sync_ld(8'h02); sync_ld(8'h03); sync_ld(8'h04); sync_ld(8'h05);
        chk("wrap_empty", {7'b0, empty}, 8'h01);

        push_b(8'hC1); push_b(8'hC2);
        step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
        chk("flush_bypass_count", {5'b0, count}, 8'd0);
        push_b(8'hC3);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("flush_stall_count", {5'b0, count}, 8'd0);
        chk("flush_stall_ir", ir, 8'h77);

`ifdef IR_INJECT_EN
        push_b(8'hA2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("inject_count", {5'b0, count}, 8'd1);
        sync_ld(8'hA2);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("inject_push_count", {5'b0, count}, 8'd1);
        sync_ld(8'h99);
`endif

        push_b(8'hD1); push_b(8'hD2);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_ir", ir, 8'h6C);
        check_state("midreset", 0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_reset_ir", ir, 8'h6C);
        step(1'b1, 8'h3E, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3E, 1'b0);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
